div255_sched: RTL and testbench

//  Shares one byte-serial divide-by-255 engine (8-bit subtract-with-borrow, one byte/cycle)

---
 rtl/div255_sched_if.sv | 38 +++
 rtl/div255_sched.sv | 143 ++++++++++++++
 tb/tb_div255_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div255_sched_if.sv
// Request/response bundle for div255_sched. master = requesters plus result consumer, slave = scheduler.
// Define DIV255_EXACT_EN to add the rsp_exact signal.
interface div255_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
`ifdef DIV255_EXACT_EN
  logic                  rsp_exact;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_exact
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_exact
  );
`else
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
`endif
endinterface

// File: rtl/div255_sched.sv
// Round-robin scheduler sharing one byte-serial divide-by-255 engine among NUM_REQ requesters.
// Define DIV255_EXACT_EN to add rsp_exact (set when the operand was an exact multiple of 255).
module div255_sched #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  div255_sched_if.slave bus,
  output logic          busy
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned CW   = ID_W + 1;

  typedef enum logic [1:0] {StIdle, StStep, StDone} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   cur_id_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [1:0]        cnt_q;
  logic [31:0]       x_q;
  logic [31:0]       y_q;
  logic [31:0]       rsp_data_q;
  logic              borrow_q;
  logic              rsp_valid_q;
  logic              busy_q;
`ifdef DIV255_EXACT_EN
  logic              exact_q;
`endif

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   rr_next;
  logic [31:0]       gnt_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [CW-1:0]     cand;
  logic [ID_W-1:0]   cand_id;
  logic [8:0]        diff;
  logic [31:0]       y_next;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    cand_id   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      cand_id = cand[ID_W-1:0];
      if (!gnt_found && bus.req_valid[cand_id]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_id;
      end
    end
  end

  always_comb begin
    gnt_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        gnt_data     = bus.req_data[32*i +: 32];
        req_ready[i] = (state_q == StIdle) && gnt_found && !rst;
      end
    end
  end

  assign rr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // y_k = y_{k-1} - x_k - borrow; the previous result byte sits in the top of y_q.
  assign diff   = {1'b0, y_q[31:24]} - {1'b0, x_q[7:0]} - {8'h00, borrow_q};
  assign y_next = {diff[7:0], y_q[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cur_id_q    <= '0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rsp_data_q  <= '0;
      borrow_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DIV255_EXACT_EN
      exact_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            x_q      <= gnt_data;
            cur_id_q <= gnt_idx;
            y_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= rr_next;
            busy_q   <= 1'b1;
            state_q  <= StStep;
          end
        end
        StStep: begin
          x_q      <= {8'h00, x_q[31:8]};
          y_q      <= y_next;
          borrow_q <= diff[8];
          cnt_q    <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            rsp_data_q  <= y_next;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= 1'b1;
`ifdef DIV255_EXACT_EN
            exact_q     <= (y_next <= 32'h0101_0101);
`endif
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;
`ifdef DIV255_EXACT_EN
  assign bus.rsp_exact = exact_q;
`endif

endmodule

// File: tb/tb_div255_sched.sv
// Directed bench for div255_sched: reset, known quotients, round-robin order, backpressure,
// mid-operation reset and a randomised run checked with 255*y == x (mod 2^32).
module tb_div255_sched;
  localparam int unsigned NUM_REQ = 4;
  localparam int NOPS = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  div255_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  div255_sched #(.NUM_REQ(NUM_REQ)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check_eq("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // One isolated operation on requester idx; expects the 5-clk grant-to-valid latency.
  task automatic do_op(input int idx, input logic [31:0] x, input logic [31:0] y, input logic ex);
    int lat;
    bus.req_valid = '0;
    bus.req_valid[idx] = 1'b1;
    bus.req_data[32*idx +: 32] = x;
    #1;
    wait_grant();
    check_eq("op_grant", 32'(bus.req_ready), 32'd1 << idx);
    tick();
    bus.req_valid = '0;
    check_eq("op_busy", 32'(busy), 32'd1);
    wait_rsp(lat);
    check_eq("op_latency", lat + 1, 32'd5);
    check_eq("op_data", bus.rsp_data, y);
    check_eq("op_id", 32'(bus.rsp_id), 32'(idx));
`ifdef DIV255_EXACT_EN
    check_eq("op_exact", 32'(bus.rsp_exact), 32'(ex));
`else
    if (ex === 1'bx) check_eq("op_exact_arg", 32'd1, 32'd0);
`endif
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("op_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check_eq("op_data_hold", bus.rsp_data, y);
    check_eq("op_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int lat;
    int last_gnt;
    int seen;
    int issued;
    int done_ops;
    int acc;
    int c;
    logic [NUM_REQ-1:0] rv;
    logic [31:0] xs [NUM_REQ];
    logic [33:0] sb_q [$];
    logic [33:0] e;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Known quotients
    do_op(0, 32'd255, 32'd1, 1'b1);
    do_op(0, 32'hFFFF_FFFF, 32'h0101_0101, 1'b1);
    do_op(0, 32'd1, 32'hFEFE_FEFF, 1'b0);
    do_op(0, 32'd255000, 32'd1000, 1'b1);
    do_op(0, 32'd0, 32'd0, 1'b1);

    // Round robin from rr_ptr=0 with all requesters active
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_data[32*i +: 32] = 32'd255 * (i + 1);
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    #1;
    last_gnt = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant();
      check_eq("rr_grant", 32'(bus.req_ready), 32'd1 << (g % 4));
      if (g > 0) check_eq("rr_period", cyc - last_gnt, 32'd6);
      last_gnt = cyc;
      tick();
      wait_rsp(lat);
      check_eq("rr_id", 32'(bus.rsp_id), 32'(g % 4));
      check_eq("rr_data", bus.rsp_data, 32'((g % 4) + 1));
      tick();
    end

    // Backpressure in DONE; rr_ptr now points at requester 1
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    bus.req_data[32*1 +: 32] = 32'd255 * 7;
    #1;
    wait_grant();
    check_eq("bp_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'hF;
    wait_rsp(lat);
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("bp_data", bus.rsp_data, 32'd7);
      check_eq("bp_id", 32'(bus.rsp_id), 32'd1);
      check_eq("bp_no_grant", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("bp_regrant", 32'(bus.req_ready), 32'h4);
    bus.req_valid = '0;
    #1;

    // Reset during STEP cnt 2
    bus.req_valid = 4'b0001;
    bus.req_data[31:0] = 32'd255 * 9;
    #1;
    wait_grant();
    check_eq("mid_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rsp_data", bus.rsp_data, 32'd0);
    check_eq("mid_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
`ifdef DIV255_EXACT_EN
    check_eq("mid_exact", 32'(bus.rsp_exact), 32'd0);
`endif
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.rsp_valid) seen++;
      tick();
    end
    check_eq("mid_no_rsp", seen, 32'd0);
    bus.req_valid = 4'hF;
    #1;
    check_eq("mid_rr_ptr", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    #1;

    // Randomised run: one engine, so responses arrive in acceptance order
    rv = '0;
    issued = 0;
    done_ops = 0;
    c = 0;
    for (int i = 0; i < 4; i++) xs[i] = '0;
    while (done_ops < NOPS && c < 20000) begin
      for (int i = 0; i < 4; i++) begin
        if (!rv[i] && issued < NOPS && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1;
          xs[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'd255 * $urandom_range(0, 16843009);
          issued++;
        end
      end
      bus.req_valid = rv;
      for (int i = 0; i < 4; i++) bus.req_data[32*i +: 32] = xs[i];
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      acc = -1;
      for (int i = 0; i < 4; i++) if (bus.req_ready[i]) acc = i;
      if (acc >= 0) sb_q.push_back({2'(acc), xs[acc]});
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("rand_spurious", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("rand_id", 32'(bus.rsp_id), 32'(e[33:32]));
          check_eq("rand_prod", bus.rsp_data * 32'd255, e[31:0]);
        end
        done_ops++;
      end
      tick();
      c++;
      if (acc >= 0) rv[acc] = 1'b0;
    end
    check_eq("rand_done", done_ops, NOPS);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
